text_mem_arbiter: RTL

Arbitrates the single-port text memory (`s_mem`: address, data, wren, q) between two requesters. The write requester loads or stores message bytes. The read requester fetches bytes for the transmit path. Only one memory access is issued per cycle. Round-robin fairness and a bounded burst length keep either side from starving the other. Read data returns through a registered, latency-matched pipeline with a valid strobe.

---
 rtl/text_mem_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/text_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : text_mem_arbiter
// Brief    : Round-robin, burst-limited arbiter sharing one single-port text
//            memory between a write requester and a read requester, with a
//            latency-matched registered read return path.
// Revision : 1.0 - initial release
// ============================================================================
module text_mem_arbiter #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int RD_LAT    = 1,
    parameter int BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_gnt,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_gnt,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q,
    output logic              busy
);

    localparam logic [1:0] c_own_idle  = 2'd0;
    localparam logic [1:0] c_own_wr    = 2'd1;
    localparam logic [1:0] c_own_rd    = 2'd2;
    localparam logic       c_side_wr   = 1'b0;
    localparam logic       c_side_rd   = 1'b1;
    localparam logic [3:0] c_burst_max = 4'(BURST_MAX);

    logic [1:0]        r_owner;
    logic [3:0]        r_burst_cnt;
    logic              r_last;
    logic [1:0]        w_owner_next;
    logic [3:0]        w_cnt_next;
    logic [3:0]        w_cnt_inc;
    logic              w_last_next;
    logic              w_gnt_wr;
    logic              w_gnt_rd;

    logic [RD_LAT-1:0] r_tag;
    logic [RD_LAT-1:0] w_tag_next;
    logic              r_rd_valid;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_busy;

    assign w_cnt_inc = (r_burst_cnt >= c_burst_max) ? c_burst_max : r_burst_cnt + 4'd1;

    // Grant decision and next arbitration state
    always_comb begin
        w_gnt_wr     = 1'b0;
        w_gnt_rd     = 1'b0;
        w_owner_next = c_own_idle;
        w_cnt_next   = 4'd0;
        w_last_next  = r_last;
        if (!reset) begin
            case (r_owner)
                c_own_wr: begin
                    if (wr_req && (r_burst_cnt < c_burst_max || !rd_req)) w_gnt_wr = 1'b1;
                    else if (rd_req)                                      w_gnt_rd = 1'b1;
                end
                c_own_rd: begin
                    if (rd_req && (r_burst_cnt < c_burst_max || !wr_req)) w_gnt_rd = 1'b1;
                    else if (wr_req)                                      w_gnt_wr = 1'b1;
                end
                default: begin
                    if (wr_req && rd_req) begin
                        if (r_last == c_side_rd) w_gnt_wr = 1'b1;
                        else                     w_gnt_rd = 1'b1;
                    end else if (wr_req) begin
                        w_gnt_wr = 1'b1;
                    end else if (rd_req) begin
                        w_gnt_rd = 1'b1;
                    end
                end
            endcase
        end
        if (w_gnt_wr) begin
            w_owner_next = c_own_wr;
            w_last_next  = c_side_wr;
            w_cnt_next   = (r_owner == c_own_wr) ? w_cnt_inc : 4'd1;
        end else if (w_gnt_rd) begin
            w_owner_next = c_own_rd;
            w_last_next  = c_side_rd;
            w_cnt_next   = (r_owner == c_own_rd) ? w_cnt_inc : 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner     <= c_own_idle;
            r_burst_cnt <= 4'd0;
            r_last      <= c_side_rd;
        end else begin
            r_owner     <= w_owner_next;
            r_burst_cnt <= w_cnt_next;
            r_last      <= w_last_next;
        end
    end

    assign wr_gnt      = w_gnt_wr;
    assign rd_gnt      = w_gnt_rd;
    assign mem_wren    = w_gnt_wr;
    assign mem_address = w_gnt_wr ? wr_addr : (w_gnt_rd ? rd_addr : '0);
    assign mem_data    = w_gnt_wr ? wr_data : '0;

    generate
        if (RD_LAT == 1) begin : g_tag_single
            assign w_tag_next = w_gnt_rd;
        end else begin : g_tag_shift
            assign w_tag_next = {r_tag[RD_LAT-2:0], w_gnt_rd};
        end
    endgenerate

    // A tag leaving the pipe marks the cycle its memory data is on mem_q
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tag      <= '0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_tag  <= w_tag_next;
            r_busy <= |w_tag_next;
            if (r_tag[RD_LAT-1]) begin
                r_rd_valid <= 1'b1;
                r_rd_data  <= mem_q;
            end else begin
                r_rd_valid <= 1'b0;
            end
        end
    end

    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_data;
    assign busy     = r_busy;

endmodule
`default_nettype wire
